// File: rtl/keypad_if.sv
// Keypad scanner bus: row sense from the matrix, column drive and encoded key outputs.
interface keypad_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with per-press debounce and {row,col} key encoding.
// Emits one key_valid strobe per debounced press; key_held tracks the press until release.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master bus
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        PRESS_DEB = 2'd1,
        HELD      = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [DIV_W-1:0]   div_cnt_q,   div_cnt_d;
    logic [DEB_W-1:0]   deb_cnt_q,   deb_cnt_d;
    logic [3:0]         sync1_q,     sync1_d;
    logic [3:0]         sync2_q,     sync2_d;
    logic [3:0]         pat_q,       pat_d;
    logic [3:0]         col_q,       col_d;
    logic [3:0]         key_code_q,  key_code_d;
    logic               key_valid_q, key_valid_d;
    logic               key_held_q,  key_held_d;

    logic [3:0]         rs;
    logic               tick;
    logic               rs_valid;
    logic [1:0]         row_idx;
    logic [1:0]         col_idx;
    logic [DEB_W-1:0]   deb_next;
    logic               deb_done;
    logic               do_accept;
    logic               do_rotate;

    assign rs       = sync2_q;
    assign tick     = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    assign deb_next = deb_cnt_q + DEB_W'(1);
    assign deb_done = (deb_next == DEB_W'(DEBOUNCE_CNT));

    // Single-zero row patterns are keys; all-ones is idle, multiple zeros are ghosts.
    always_comb begin
        rs_valid = 1'b1;
        row_idx  = 2'd0;
        case (rs)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: rs_valid = 1'b0;
        endcase
    end

    always_comb begin
        case (col_q)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        pat_d       = pat_q;
        col_d       = col_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        sync1_d     = bus.row_in;
        sync2_d     = sync1_q;
        div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);
        do_accept   = 1'b0;
        do_rotate   = 1'b0;

        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (rs_valid) begin
                        pat_d = rs;
                        if (DEBOUNCE_CNT == 1) begin
                            do_accept = 1'b1;
                        end else begin
                            deb_cnt_d = DEB_W'(1);
                            state_d   = PRESS_DEB;
                        end
                    end else begin
                        do_rotate = 1'b1;
                    end
                end
                PRESS_DEB: begin
                    // A mismatch drops back to SCAN on the same column so it is re-sampled.
                    if (rs == pat_q) begin
                        if (deb_done) do_accept = 1'b1;
                        else          deb_cnt_d = deb_next;
                    end else begin
                        deb_cnt_d = '0;
                        state_d   = SCAN;
                    end
                end
                HELD: begin
                    if (rs == 4'b1111) begin
                        if (deb_done) begin
                            deb_cnt_d  = '0;
                            key_held_d = 1'b0;
                            do_rotate  = 1'b1;
                            state_d    = SCAN;
                        end else begin
                            deb_cnt_d = deb_next;
                        end
                    end else begin
                        deb_cnt_d = '0;
                    end
                end
                default: state_d = SCAN;
            endcase
        end

        if (do_accept) begin
            key_code_d  = {row_idx, col_idx};
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            deb_cnt_d   = '0;
            state_d     = HELD;
        end

        if (do_rotate) begin
            col_d = {col_q[2:0], col_q[3]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            div_cnt_q   <= '0;
            deb_cnt_q   <= '0;
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            pat_q       <= 4'b1111;
            col_q       <= 4'b1110;
            key_code_q  <= 4'b0000;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            pat_q       <= pat_d;
            col_q       <= col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign bus.col_out   = col_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3.
// Sample ticks act on posedges 4,8,12,... counted from reset release; rows are set 3 cycles ahead.
module tb_keypad_scanner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   nvalid = 0;
    int   col_bad = 0;
    int   dbl_valid = 0;
    logic prev_valid = 1'b0;

    keypad_if kif ();

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (kif.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Track strobes, back-to-back strobes and column drive legality between edges.
    always @(negedge clk) begin
        if (!rst) begin
            if ($countones(kif.col_out) != 3) col_bad = col_bad + 1;
            if (kif.key_valid) begin
                nvalid = nvalid + 1;
                if (prev_valid) dbl_valid = dbl_valid + 1;
            end
            prev_valid = kif.key_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        kif.row_in = 4'b1111;
        @(posedge clk);
        #1;
        check("rst_col",   int'(kif.col_out),   4'b1110);
        check("rst_code",  int'(kif.key_code),  0);
        check("rst_valid", int'(kif.key_valid), 0);
        check("rst_held",  int'(kif.key_held),  0);
        @(negedge clk);
        rst = 1'b0;

        // Idle rotation
        wait_cyc(3);  check("idle_col3",  int'(kif.col_out), 4'b1110);
        wait_cyc(4);  check("idle_col4",  int'(kif.col_out), 4'b1101);
        wait_cyc(8);  check("idle_col8",  int'(kif.col_out), 4'b1011);
        wait_cyc(12); check("idle_col12", int'(kif.col_out), 4'b0111);
        wait_cyc(16); check("idle_col16", int'(kif.col_out), 4'b1110);
        check("idle_code",   int'(kif.key_code), 0);
        check("idle_nvalid", nvalid, 0);

        // Clean press row 2 / col 1, first seen at tick on posedge 24
        wait_cyc(21); kif.row_in = 4'b1011;
        wait_cyc(24); check("press_freeze24", int'(kif.col_out), 4'b1101);
        wait_cyc(28); check("press_freeze28", int'(kif.col_out), 4'b1101);
        wait_cyc(31); check("press_novalid31", int'(kif.key_valid), 0);
        wait_cyc(32);
        check("press_valid", int'(kif.key_valid), 1);
        check("press_code",  int'(kif.key_code),  4'b1001);
        check("press_held",  int'(kif.key_held),  1);
        wait_cyc(33);
        check("press_valid_clr", int'(kif.key_valid), 0);
        check("press_nvalid",    nvalid, 1);
        wait_cyc(61); kif.row_in = 4'b1111;
        wait_cyc(71);
        check("rel_held71", int'(kif.key_held), 1);
        check("rel_col71",  int'(kif.col_out),  4'b1101);
        wait_cyc(72);
        check("rel_held72", int'(kif.key_held), 0);
        check("rel_col72",  int'(kif.col_out),  4'b1011);

        // Press bounce on row 0 / col 3, stable press first seen at posedge 88
        wait_cyc(77); kif.row_in = 4'b1110;
        wait_cyc(81); kif.row_in = 4'b1111;
        wait_cyc(84);
        check("bounce_col_kept", int'(kif.col_out), 4'b0111);
        check("bounce_nvalid",   nvalid, 1);
        wait_cyc(85); kif.row_in = 4'b1110;
        wait_cyc(95); check("bounce_novalid95", int'(kif.key_valid), 0);
        wait_cyc(96);
        check("bounce_valid", int'(kif.key_valid), 1);
        check("bounce_code",  int'(kif.key_code),  4'b0011);
        check("bounce_held",  int'(kif.key_held),  1);

        // Release bounce: 1111, 1111, 1110, 1111 x3
        wait_cyc(97);
        check("bounce_nvalid2", nvalid, 2);
        kif.row_in = 4'b1111;
        wait_cyc(105); kif.row_in = 4'b1110;
        wait_cyc(109); kif.row_in = 4'b1111;
        wait_cyc(112); check("relb_held112", int'(kif.key_held), 1);
        wait_cyc(119);
        check("relb_held119", int'(kif.key_held), 1);
        check("relb_col119",  int'(kif.col_out),  4'b0111);
        wait_cyc(120);
        check("relb_held120", int'(kif.key_held), 0);
        check("relb_col120",  int'(kif.col_out),  4'b1110);
        check("relb_nvalid",  nvalid, 2);

        // Ghost pattern keeps rotating
        wait_cyc(121); kif.row_in = 4'b1010;
        wait_cyc(124); check("ghost_col124", int'(kif.col_out), 4'b1101);
        wait_cyc(128); check("ghost_col128", int'(kif.col_out), 4'b1011);
        wait_cyc(132); check("ghost_col132", int'(kif.col_out), 4'b0111);
        wait_cyc(133);
        check("ghost_held",   int'(kif.key_held), 0);
        check("ghost_nvalid", nvalid, 2);
        kif.row_in = 4'b1111;

        // Reset after the 2nd matching tick of a row 1 / col 0 press
        wait_cyc(137); kif.row_in = 4'b1101;
        wait_cyc(140); check("rdeb_col140", int'(kif.col_out), 4'b1110);
        wait_cyc(145);
        rst = 1'b1;
        #1;
        check("rmid_col",   int'(kif.col_out),   4'b1110);
        check("rmid_held",  int'(kif.key_held),  0);
        check("rmid_valid", int'(kif.key_valid), 0);
        check("rmid_code",  int'(kif.key_code),  0);
        check("rmid_nvalid", nvalid, 2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(11);
        check("redet_novalid11", int'(kif.key_valid), 0);
        check("redet_col11",     int'(kif.col_out),   4'b1110);
        wait_cyc(12);
        check("redet_valid", int'(kif.key_valid), 1);
        check("redet_code",  int'(kif.key_code),  4'b0100);
        check("redet_held",  int'(kif.key_held),  1);
        wait_cyc(13);
        check("redet_valid_clr", int'(kif.key_valid), 0);
        check("redet_nvalid",    nvalid, 3);

        check("col_onehot_zero", col_bad, 0);
        check("valid_b2b",       dbl_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
